score_combo_counter: RTL and testbench

//  Parametrised BCD score and combo counter for the rhythm-game judge path. It sits between the hit

---
 rtl/score_combo_counter_if.sv | 8 +
 rtl/score_combo_counter.sv | 84 ++++++++
 tb/tb_score_combo_counter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/score_combo_counter_if.sv
// score_combo_counter_if: ready/valid hit handshake between the hit judge and the score counter
interface score_combo_counter_if;
  logic       hit_valid;
  logic [1:0] hit_grade;
  logic       hit_ready;
  modport master (output hit_valid, hit_grade, input hit_ready);
  modport slave (input hit_valid, hit_grade, output hit_ready);
endinterface

// File: rtl/score_combo_counter.sv
// score_combo_counter: saturating BCD score, combo and max-combo tracker with threshold bonus
module score_combo_counter #(
  parameter int                  DIGITS       = 4,
  parameter int                  COMBO_WIDTH  = 8,
  parameter logic [4*DIGITS-1:0] OK_PTS       = 'h1,
  parameter logic [4*DIGITS-1:0] GOOD_PTS     = 'h3,
  parameter logic [4*DIGITS-1:0] BONUS_PTS    = 'h1,
  parameter int                  BONUS_THRESH = 10
) (
  input  logic                     clock,
  input  logic                     clear_b,
  input  logic                     enable,
  score_combo_counter_if.slave     hit,
  output logic [4*DIGITS-1:0]      score,
  output logic [COMBO_WIDTH-1:0]   combo,
  output logic [COMBO_WIDTH-1:0]   max_combo,
  output logic                     score_sat,
  output logic                     bonus_pulse
);
  localparam int SW = 4 * DIGITS;
  typedef enum logic [1:0] {IDLE, ADD, BONUS} state_t;
  state_t                 state_q, state_d;
  logic [1:0]             grade_q, grade_d;
  logic [SW-1:0]          score_q, score_d;
  logic [COMBO_WIDTH-1:0] combo_q, combo_d, max_q, max_d, combo_inc;
  logic                   sat_q, sat_d, bonus_q, bonus_d;
  logic                   accept, miss, upd, carry;
  logic [SW-1:0]          addend, sum;
  logic [4:0]             dsum;
  always_ff @(posedge clock or negedge clear_b)
    if (!clear_b) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clock or negedge clear_b)
    if (!clear_b) begin
      grade_q <= '0;
      score_q <= '0;
      combo_q <= '0;
      max_q   <= '0;
      sat_q   <= 1'b0;
      bonus_q <= 1'b0;
    end else begin
      grade_q <= grade_d;
      score_q <= score_d;
      combo_q <= combo_d;
      max_q   <= max_d;
      sat_q   <= sat_d;
      bonus_q <= bonus_d;
    end
  assign accept    = hit.hit_valid && hit.hit_ready;
  assign miss      = !(grade_q == 2'b01 || grade_q == 2'b10);
  assign combo_inc = &combo_q ? combo_q : combo_q + COMBO_WIDTH'(1);
  always_comb begin
    state_d = state_q == IDLE ? (accept ? ADD : IDLE) :
              state_q == ADD && !miss && 32'(combo_inc) >= BONUS_THRESH ? BONUS : IDLE;
    grade_d = accept ? hit.hit_grade : grade_q;
  end
  // Digit-serial BCD add; carry out of the top digit means the score overflowed
  always_comb begin
    addend = state_q == BONUS ? BONUS_PTS : grade_q == 2'b10 ? GOOD_PTS : OK_PTS;
    carry  = 1'b0;
    sum    = '0;
    dsum   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, score_q[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + 5'(carry);
      carry = dsum > 5'd9;
      dsum = carry ? dsum + 5'd6 : dsum;
      sum[4*i +: 4] = dsum[3:0];
    end
  end
  always_comb begin
    upd           = state_q == BONUS || (state_q == ADD && !miss);
    score_d       = upd ? (carry ? {DIGITS{4'h9}} : sum) : score_q;
    sat_d         = sat_q | (upd & carry);
    combo_d       = state_q == ADD ? (miss ? '0 : combo_inc) : combo_q;
    max_d         = state_q == ADD && !miss && combo_inc > max_q ? combo_inc : max_q;
    bonus_d       = state_q == BONUS;
    hit.hit_ready = enable && state_q == IDLE;
  end
  assign score       = score_q;
  assign combo       = combo_q;
  assign max_combo   = max_q;
  assign score_sat   = sat_q;
  assign bonus_pulse = bonus_q;
endmodule

// File: tb/tb_score_combo_counter.sv
// tb_score_combo_counter: table-driven hits on three parameter variants plus reset/enable/hold sequences
module tb_score_combo_counter;
  logic clock, clear_b, enable;
  score_combo_counter_if if0 ();
  score_combo_counter_if if1 ();
  score_combo_counter_if if2 ();
  logic [15:0] score0, score2;
  logic [3:0]  score1;
  logic [7:0]  combo0, max0, combo1, max1;
  logic [1:0]  combo2, max2;
  logic        sat0, sat1, sat2, bp0, bp1, bp2;
  int n_tests = 0, n_fail = 0;

  score_combo_counter u0 (.clock(clock), .clear_b(clear_b), .enable(enable), .hit(if0),
    .score(score0), .combo(combo0), .max_combo(max0), .score_sat(sat0), .bonus_pulse(bp0));
  score_combo_counter #(.DIGITS(1)) u1 (.clock(clock), .clear_b(clear_b), .enable(enable), .hit(if1),
    .score(score1), .combo(combo1), .max_combo(max1), .score_sat(sat1), .bonus_pulse(bp1));
  score_combo_counter #(.COMBO_WIDTH(2)) u2 (.clock(clock), .clear_b(clear_b), .enable(enable), .hit(if2),
    .score(score2), .combo(combo2), .max_combo(max2), .score_sat(sat2), .bonus_pulse(bp2));

  initial clock = 0;
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog expired: got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int d; bit rst; logic [1:0] g; logic [31:0] s; int c; int m; bit sat; int busy; int bon;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(int d, bit rst, logic [1:0] g, logic [31:0] s, int c, int m,
                             bit sat, int busy, int bon);
    vec_t r;
    r = '{d, rst, g, s, c, m, sat, busy, bon};
    return r;
  endfunction

  function automatic logic [31:0] sc(int d);
    return d == 0 ? {16'h0, score0} : d == 1 ? {28'h0, score1} : {16'h0, score2};
  endfunction
  function automatic logic [31:0] cb(int d);
    return d == 0 ? {24'h0, combo0} : d == 1 ? {24'h0, combo1} : {30'h0, combo2};
  endfunction
  function automatic logic [31:0] mx(int d);
    return d == 0 ? {24'h0, max0} : d == 1 ? {24'h0, max1} : {30'h0, max2};
  endfunction
  function automatic logic st(int d);
    return d == 0 ? sat0 : d == 1 ? sat1 : sat2;
  endfunction
  function automatic logic bp(int d);
    return d == 0 ? bp0 : d == 1 ? bp1 : bp2;
  endfunction
  function automatic logic rdy(int d);
    return d == 0 ? if0.hit_ready : d == 1 ? if1.hit_ready : if2.hit_ready;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic set_in(int d, logic val, logic [1:0] g);
    if (d == 0) begin if0.hit_valid = val; if0.hit_grade = g; end
    else if (d == 1) begin if1.hit_valid = val; if1.hit_grade = g; end
    else begin if2.hit_valid = val; if2.hit_grade = g; end
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear_b = 0;
    @(negedge clock);
    clear_b = 1;
  endtask

  // Present one hit, then watch four cycles for ready-low time and bonus pulses
  task automatic hit(int d, logic [1:0] g, output int busy, output int bon);
    int w = 0;
    while (!rdy(d) && w < 20) begin
      @(negedge clock);
      w++;
    end
    if (!rdy(d)) chk("ready_wait", d, 0, 1);
    set_in(d, 1'b1, g);
    @(posedge clock);
    @(negedge clock);
    set_in(d, 1'b0, 2'b00);
    busy = 0;
    bon = 0;
    for (int i = 0; i < 4; i++) begin
      if (!rdy(d)) busy++;
      if (bp(d)) bon++;
      if (i < 3) @(negedge clock);
    end
  endtask

  initial begin
    int busy, bon;
    int sc10[10];
    sc10 = '{'h3, 'h6, 'h9, 'h12, 'h15, 'h18, 'h21, 'h24, 'h27, 'h31};
    clear_b = 0;
    enable = 1;
    set_in(0, 0, 0);
    set_in(1, 0, 0);
    set_in(2, 0, 0);
    tbl.push_back(v(0, 1, 2, 'h3, 1, 1, 0, 1, 0));
    tbl.push_back(v(0, 0, 2, 'h6, 2, 2, 0, 1, 0));
    tbl.push_back(v(0, 0, 2, 'h9, 3, 3, 0, 1, 0));
    for (int i = 1; i <= 10; i++)
      tbl.push_back(v(0, i == 1, 2, sc10[i-1], i, i, 0, i == 10 ? 2 : 1, i == 10 ? 1 : 0));
    tbl.push_back(v(0, 0, 0, 'h31, 0, 10, 0, 1, 0));
    tbl.push_back(v(0, 0, 1, 'h32, 1, 10, 0, 1, 0));
    tbl.push_back(v(0, 0, 3, 'h32, 0, 10, 0, 1, 0));
    tbl.push_back(v(1, 1, 2, 'h3, 1, 1, 0, 1, 0));
    tbl.push_back(v(1, 0, 2, 'h6, 2, 2, 0, 1, 0));
    tbl.push_back(v(1, 0, 2, 'h9, 3, 3, 0, 1, 0));
    tbl.push_back(v(1, 0, 2, 'h9, 4, 4, 1, 1, 0));
    tbl.push_back(v(1, 0, 1, 'h9, 5, 5, 1, 1, 0));
    tbl.push_back(v(2, 1, 1, 'h1, 1, 1, 0, 1, 0));
    tbl.push_back(v(2, 0, 1, 'h2, 2, 2, 0, 1, 0));
    tbl.push_back(v(2, 0, 1, 'h3, 3, 3, 0, 1, 0));
    tbl.push_back(v(2, 0, 1, 'h4, 3, 3, 0, 1, 0));
    tbl.push_back(v(2, 0, 1, 'h5, 3, 3, 0, 1, 0));
    @(negedge clock);
    @(negedge clock);
    clear_b = 1;
    #1;
    chk("rst_score", 0, {16'h0, score0}, 0);
    chk("rst_ready", 0, {31'h0, if0.hit_ready}, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      hit(tbl[i].d, tbl[i].g, busy, bon);
      chk("score", i, sc(tbl[i].d), tbl[i].s);
      chk("combo", i, cb(tbl[i].d), tbl[i].c);
      chk("max_combo", i, mx(tbl[i].d), tbl[i].m);
      chk("score_sat", i, {31'h0, st(tbl[i].d)}, {31'h0, tbl[i].sat});
      chk("busy_cycles", i, busy, tbl[i].busy);
      chk("bonus_pulses", i, bon, tbl[i].bon);
    end

    // Valid held through the busy cycle must be taken only once
    @(negedge clock);
    set_in(2, 1, 2'b01);
    @(posedge clock);
    @(negedge clock);
    chk("hold_ready_low", 0, {31'h0, if2.hit_ready}, 0);
    @(posedge clock);
    @(negedge clock);
    set_in(2, 0, 2'b00);
    repeat (3) @(negedge clock);
    chk("hold_score", 0, sc(2), 'h6);
    chk("hold_combo", 0, cb(2), 3);

    // Async reset in the middle of an ADD discards the pending update
    do_reset();
    hit(0, 2'b10, busy, bon);
    chk("pre_rst_score", 0, sc(0), 'h3);
    @(negedge clock);
    set_in(0, 1, 2'b10);
    @(posedge clock);
    #2;
    clear_b = 0;
    #1;
    chk("async_score", 0, sc(0), 0);
    chk("async_combo", 0, cb(0), 0);
    chk("async_max", 0, mx(0), 0);
    chk("async_sat", 0, {31'h0, sat1}, 0);
    chk("async_bonus", 0, {31'h0, bp0}, 0);
    set_in(0, 0, 2'b00);
    @(negedge clock);
    clear_b = 1;
    #1;
    chk("rel_ready", 0, {31'h0, if0.hit_ready}, 1);
    repeat (2) @(negedge clock);
    chk("rel_score", 0, sc(0), 0);

    // No accepts while enable is low
    enable = 0;
    #1;
    chk("dis_ready", 0, {31'h0, if0.hit_ready}, 0);
    set_in(0, 1, 2'b10);
    repeat (3) @(negedge clock);
    set_in(0, 0, 2'b00);
    chk("dis_score", 0, sc(0), 0);
    enable = 1;
    #1;
    chk("en_ready", 0, {31'h0, if0.hit_ready}, 1);

    // Enable dropping mid-operation still lets the ADD complete
    @(negedge clock);
    set_in(0, 1, 2'b10);
    @(posedge clock);
    @(negedge clock);
    set_in(0, 0, 2'b00);
    enable = 0;
    repeat (2) @(negedge clock);
    chk("mid_dis_score", 0, sc(0), 'h3);
    chk("mid_dis_ready", 0, {31'h0, if0.hit_ready}, 0);
    enable = 1;
    #1;
    chk("mid_en_ready", 0, {31'h0, if0.hit_ready}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
